// File: rtl/mem_model.sv
// mem_model: single-port behavioural memory with request/acknowledge handshake.
// Latency: ack is high LAT cycles after the capture edge; one transaction per LAT+1 cycles.
// Backpressure: requests are level-held until ack; only IDLE samples them, and a write wins over a read.
// Optional byte write enables are built in when MEM_MODEL_BE_EN is defined.
module mem_model #(
  parameter int AW  = 17,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ram_wr_req,
  output logic          ram_wr_ack,
  input  logic          ram_rd_req,
  output logic          ram_rd_ack,
  input  logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_wdata,
`ifdef MEM_MODEL_BE_EN
  input  logic [DW/8-1:0] ram_wbe,
`endif
  output logic [DW-1:0] ram_rdata
);

  localparam int NB = DW / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [DW-1:0] mem [2**AW];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_op_q, wr_op_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          wr_ack_q, wr_ack_d;
  logic          rd_ack_q, rd_ack_d;
  logic          wr_cap;
  logic [NB-1:0] be;

`ifdef MEM_MODEL_BE_EN
  assign be = ram_wbe;
`else
  assign be = '1;
`endif

  // Next-state logic: capture in IDLE, count down in WAIT, single ack cycle in ACK.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_op_d  = wr_op_q;
    hold_d   = hold_q;
    rdata_d  = rdata_q;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    wr_cap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ram_wr_req || ram_rd_req) begin
          // Write has priority; a simultaneous read stays pending for the next IDLE edge.
          wr_op_d = ram_wr_req;
          wr_cap  = ram_wr_req;
          cnt_d   = 4'(LAT - 1);
          if (!ram_wr_req) hold_d = mem[ram_addr];
          state_d = (LAT == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Acks and read data are registered on the edge that enters ACK.
    if (state_d == ST_ACK && state_q != ST_ACK) begin
      wr_ack_d = wr_op_d;
      rd_ack_d = !wr_op_d;
      if (!wr_op_d) rdata_d = hold_d;
    end
  end

  // Control and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      wr_op_q  <= 1'b0;
      hold_q   <= '0;
      rdata_q  <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_op_q  <= wr_op_d;
      hold_q   <= hold_d;
      rdata_q  <= rdata_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
    end
  end

  // Storage commits at the capture edge, so later address/data changes cannot affect it.
  always_ff @(posedge clk) begin
    if (!rst && wr_cap) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  assign ram_wr_ack = wr_ack_q;
  assign ram_rd_ack = rd_ack_q;
  assign ram_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_model.sv
// Directed bench for mem_model: three instances with LAT = 1, 4 and 8.
module tb_mem_model;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  wr_req, rd_req, wr_ack, rd_ack;
  logic [16:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
`ifdef MEM_MODEL_BE_EN
  logic [3:0]  wbe   [3];
`endif

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_model #(.AW(17), .DW(32), .LAT((g == 0) ? 1 : ((g == 1) ? 4 : 8))) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .ram_wr_req(wr_req[g]),
      .ram_wr_ack(wr_ack[g]),
      .ram_rd_req(rd_req[g]),
      .ram_rd_ack(rd_ack[g]),
      .ram_addr  (addr[g]),
      .ram_wdata (wdata[g]),
`ifdef MEM_MODEL_BE_EN
      .ram_wbe   (wbe[g]),
`endif
      .ram_rdata (rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge, wait (bounded) for an ack, drop the request
  // on the edge that ends the ack cycle. Optionally disturb addr/wdata during WAIT.
  task automatic xact(input int k, input bit wr, input bit rd, input logic [16:0] a,
                      input logic [31:0] d, input logic [3:0] be, input bit mut,
                      output int n, output logic wa, output logic ra, output logic [31:0] rd_out);
    logic [31:0] old;
    old = rdata[k];
    n = 0; wa = 1'b0; ra = 1'b0; rd_out = '0;
    wr_req[k] = wr; rd_req[k] = rd; addr[k] = a; wdata[k] = d;
`ifdef MEM_MODEL_BE_EN
    wbe[k] = be;
`else
    if (be != 4'hF) $display("note: byte enables ignored in this build");
`endif
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (wr_ack[k] || rd_ack[k]) begin
        n = i; wa = wr_ack[k]; ra = rd_ack[k]; rd_out = rdata[k];
        break;
      end
      chk("rdata_hold", rdata[k], old);
      if (mut && i == 1) begin
        addr[k]  = a ^ 17'h1;
        wdata[k] = ~d;
      end
    end
    @(posedge clk); #1;
    wr_req[k] = 1'b0; rd_req[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_wr(input int k, input logic [16:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit mut, input string tag);
    int n; logic wa, ra; logic [31:0] r;
    xact(k, 1'b1, 1'b0, a, d, be, mut, n, wa, ra, r);
    chk({tag, "_lat"}, 32'(n), 32'(lat_of(k)));
    chk({tag, "_wack"}, {30'd0, wa, ra}, 32'h2);
  endtask

  task automatic do_rd(input int k, input logic [16:0] a, input logic [31:0] exp, input string tag);
    int n; logic wa, ra; logic [31:0] r;
    xact(k, 1'b0, 1'b1, a, 32'h0, 4'hF, 1'b0, n, wa, ra, r);
    chk({tag, "_lat"}, 32'(n), 32'(lat_of(k)));
    chk({tag, "_rack"}, {30'd0, wa, ra}, 32'h1);
    chk({tag, "_data"}, r, exp);
  endtask

  initial begin
    int acks;
    rst = 3'b111; wr_req = '0; rd_req = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdata[k] = '0;
`ifdef MEM_MODEL_BE_EN
      wbe[k] = 4'hF;
`endif
    end
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    @(negedge clk);

    // Reset state
    for (int k = 0; k < 3; k++) begin
      chk("rst_acks", {30'd0, wr_ack[k], rd_ack[k]}, 32'h0);
      chk("rst_rdata", rdata[k], 32'h0);
    end

    // LAT=1 write then read
    do_wr(0, 17'h00010, 32'hDEADBEEF, 4'hF, 1'b0, "l1_wr");
    do_rd(0, 17'h00010, 32'hDEADBEEF, "l1_rd");

    // LAT=4 at top address; rdata must hold during wait cycles
    do_wr(1, 17'h1FFFF, 32'hA5A5A5A5, 4'hF, 1'b0, "l4_wr");
    do_rd(1, 17'h1FFFF, 32'hA5A5A5A5, "l4_rd");

    // Simultaneous write and read on LAT=1: write first, read sees new data
    wr_req[0] = 1'b1; rd_req[0] = 1'b1; addr[0] = 17'h00020; wdata[0] = 32'h12345678;
    @(negedge clk);
    chk("sim_wr_first", {30'd0, wr_ack[0], rd_ack[0]}, 32'h2);
    @(posedge clk); #1 wr_req[0] = 1'b0;
    @(negedge clk);
    chk("sim_idle_gap", {30'd0, wr_ack[0], rd_ack[0]}, 32'h0);
    @(negedge clk);
    chk("sim_rd_ack", {30'd0, wr_ack[0], rd_ack[0]}, 32'h1);
    chk("sim_rd_data", rdata[0], 32'h12345678);
    @(posedge clk); #1 rd_req[0] = 1'b0;
    @(negedge clk);

    // Reset in WAIT during a LAT=8 read
    do_wr(2, 17'h00040, 32'hCAFEF00D, 4'hF, 1'b0, "l8_wr");
    do_rd(2, 17'h00040, 32'hCAFEF00D, "l8_rd");
    rd_req[2] = 1'b1; addr[2] = 17'h00040;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(rd_ack[2]);
    end
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0; rd_req[2] = 1'b0;
    @(negedge clk);
    chk("rstw_rdata", rdata[2], 32'h0);
    repeat (12) begin
      acks += int'(rd_ack[2]);
      @(negedge clk);
    end
    chk("rstw_no_ack", 32'(acks), 32'h0);
    do_rd(2, 17'h00040, 32'hCAFEF00D, "rstw_reread");

    // Address/data changed during WAIT must not affect the captured write
    do_wr(1, 17'h00031, 32'h31313131, 4'hF, 1'b0, "mut_pre");
    do_wr(1, 17'h00030, 32'h0BADCAFE, 4'hF, 1'b1, "mut_wr");
    do_rd(1, 17'h00030, 32'h0BADCAFE, "mut_rd_orig");
    do_rd(1, 17'h00031, 32'h31313131, "mut_rd_other");

`ifdef MEM_MODEL_BE_EN
    // Byte enables: partial and empty masks
    do_wr(0, 17'h00050, 32'h11223344, 4'hF, 1'b0, "be_full");
    do_wr(0, 17'h00050, 32'hAABBCCDD, 4'b0101, 1'b0, "be_part");
    do_rd(0, 17'h00050, 32'h11BB33DD, "be_rd");
    do_wr(0, 17'h00050, 32'hFFFFFFFF, 4'b0000, 1'b0, "be_none");
    do_rd(0, 17'h00050, 32'h11BB33DD, "be_none_rd");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
